regfile_host: RTL and testbench

Command-driven host port for the 4×8-bit register file. It turns a valid/ready command stream into the register file's write-strobe and read-address signals, then returns read results on a valid/ready response stream. Its main user is the debug/load path, which preloads registers before the datapath runs and dumps them afterwards. It sits between the debug command source and the register file, on the register file's initiator side.

---
 rtl/regfile_pkg.sv | 24 ++
 rtl/rsp_queue.sv | 66 ++++++
 rtl/regfile_host.sv | 148 ++++++++++++++
 tb/tb_regfile_host.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants, command opcodes and host FSM states for the 4x8 register file.
package regfile_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 2;
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_READ  = 2'd1,
    OP_DUMP  = 2'd2,
    OP_NOP   = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ISSUE,
    RD_WAIT,
    RD_CAPTURE,
    RSP
  } state_t;

endpackage

// File: rtl/rsp_queue.sv
// Two-entry {reg, data} response FIFO; head entry is always slot 0 so its outputs come straight from flops.
module rsp_queue #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              push_pair,
  input  logic              pop,
  input  logic [ADDR_W-1:0] reg_a,
  input  logic [DATA_W-1:0] data_a,
  input  logic [ADDR_W-1:0] reg_b,
  input  logic [DATA_W-1:0] data_b,
  output logic              full,
  output logic              empty,
  output logic [1:0]        count,
  output logic [ADDR_W-1:0] head_reg,
  output logic [DATA_W-1:0] head_data
);

  localparam int ENT_W = ADDR_W + DATA_W;

  logic [1:0][ENT_W-1:0] ent_q, ent_d;
  logic [1:0]            vld_q, vld_d;

  // Pop shifts slot 1 forward first, then new entries fill the lowest free slot.
  // A pair push is only issued into an empty queue.
  always_comb begin
    ent_d = ent_q;
    vld_d = vld_q;
    if (pop && vld_q[0]) begin
      ent_d[0] = ent_q[1];
      vld_d    = {1'b0, vld_q[1]};
    end
    if (push) begin
      if (!vld_d[0]) begin
        ent_d[0] = {reg_a, data_a};
        vld_d[0] = 1'b1;
        if (push_pair) begin
          ent_d[1] = {reg_b, data_b};
          vld_d[1] = 1'b1;
        end
      end else if (!vld_d[1]) begin
        ent_d[1] = {reg_a, data_a};
        vld_d[1] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      ent_q <= '0;
    end else begin
      vld_q <= vld_d;
      ent_q <= ent_d;
    end
  end

  assign empty = ~vld_q[0];
  assign full  = vld_q[1];
  assign count = {1'b0, vld_q[0]} + {1'b0, vld_q[1]};
  assign {head_reg, head_data} = ent_q[0];

endmodule

// File: rtl/regfile_host.sv
// Command-driven host port: turns WRITE/READ/DUMP commands into register file strobes and returns read data.
module regfile_host #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_reg,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0] WriteData,
  output logic [ADDR_W-1:0] ReadReg1,
  output logic [ADDR_W-1:0] ReadReg2,
  input  logic [DATA_W-1:0] ReadData1,
  input  logic [DATA_W-1:0] ReadData2,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ADDR_W-1:0] rsp_reg,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy
);

  import regfile_pkg::*;

  state_t     state;
  logic       dump_q;
  logic       pair_q;
  logic       reg_write_q;
  logic       q_push, q_pop, q_full, q_empty;
  logic [1:0] q_count, q_left;

  // Reset masks the strobe so a write interrupted by reset never lands.
  assign RegWrite  = reg_write_q & ~reset;
  assign rsp_valid = ~q_empty;
  assign q_pop     = rsp_valid & rsp_ready;
  assign q_left    = q_count - {1'b0, q_pop};

  always_comb begin
    q_push = 1'b0;
    if (state == RD_CAPTURE)
      q_push = !q_full && (q_empty || !dump_q);
  end

  rsp_queue #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rsp_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (q_push),
    .push_pair (dump_q),
    .pop       (q_pop),
    .reg_a     (ReadReg1),
    .data_a    (ReadData1),
    .reg_b     (ReadReg2),
    .data_b    (ReadData2),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count),
    .head_reg  (rsp_reg),
    .head_data (rsp_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      reg_write_q <= 1'b0;
      WriteReg    <= '0;
      WriteData   <= '0;
      ReadReg1    <= '0;
      ReadReg2    <= '0;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      dump_q      <= 1'b0;
      pair_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            case (op_t'(cmd_op))
              OP_WRITE: begin
                state       <= WR;
                reg_write_q <= 1'b1;
                WriteReg    <= cmd_reg;
                WriteData   <= cmd_data;
                cmd_ready   <= 1'b0;
                busy        <= 1'b1;
              end
              OP_READ: begin
                state     <= RD_ISSUE;
                ReadReg1  <= cmd_reg;
                dump_q    <= 1'b0;
                cmd_ready <= 1'b0;
                busy      <= 1'b1;
              end
              OP_DUMP: begin
                state     <= RD_ISSUE;
                ReadReg1  <= '0;
                ReadReg2  <= ADDR_W'(1);
                dump_q    <= 1'b1;
                pair_q    <= 1'b0;
                cmd_ready <= 1'b0;
                busy      <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        WR: begin
          reg_write_q <= 1'b0;
          state       <= IDLE;
          cmd_ready   <= 1'b1;
          busy        <= 1'b0;
        end
        RD_ISSUE:   state <= RD_WAIT;
        RD_WAIT:    state <= RD_CAPTURE;
        RD_CAPTURE: if (q_push) state <= RSP;
        RSP: begin
          // The second dump pair is issued while the last first-pair response
          // drains; RD_CAPTURE then waits for the queue to empty before pushing.
          if (dump_q && !pair_q) begin
            if (q_left <= 2'd1) begin
              state    <= RD_ISSUE;
              pair_q   <= 1'b1;
              ReadReg1 <= ADDR_W'(2);
              ReadReg2 <= ADDR_W'(3);
            end
          end else if (q_left == 2'd0) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          reg_write_q <= 1'b0;
          cmd_ready   <= 1'b1;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_host.sv
// Bench for regfile_host: behavioural register file plus an architectural scoreboard of expected responses.
module tb_regfile_host;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [1:0] cmd_reg;
  logic [7:0] cmd_data;
  logic       RegWrite;
  logic [1:0] WriteReg;
  logic [7:0] WriteData;
  logic [1:0] ReadReg1, ReadReg2;
  logic [7:0] ReadData1, ReadData2;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [1:0] rsp_reg;
  logic [7:0] rsp_data;
  logic       busy;

  regfile_host #(.DATA_W(8), .ADDR_W(2)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .ReadData1(ReadData1), .ReadData2(ReadData2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_reg(rsp_reg), .rsp_data(rsp_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Register file: writes when strobed, otherwise refreshes both read ports.
  logic [7:0] rf [4];
  always @(posedge clk) begin
    if (RegWrite) rf[WriteReg] <= WriteData;
    else begin
      ReadData1 <= rf[ReadReg1];
      ReadData2 <= rf[ReadReg2];
    end
  end

  int asserts = 0;
  int errors  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ready_mode = 1;
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       rsp_ready = 1'b0;
      1:       rsp_ready = 1'b1;
      default: rsp_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    asserts++;
    errors++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  typedef struct { logic [1:0] r; logic [7:0] d; } rsp_t;
  typedef struct { int c; logic [1:0] r; logic [7:0] d; } hs_t;
  rsp_t       exp_q[$];
  hs_t        hs_log[$];
  logic [7:0] arch [4];
  bit         mon_en = 0;
  bit         wr_expect = 0;
  logic [1:0] wr_reg_e;
  logic [7:0] wr_dat_e;
  bit         hold = 0;
  logic [1:0] hold_r;
  logic [7:0] hold_d;

  // Compare process: architectural register contents and an ordered list of owed responses.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("ready_vs_busy", cmd_ready, !busy);
      chk("regwrite", RegWrite, wr_expect && !reset);
      if (RegWrite && wr_expect) begin
        chk("write_reg", WriteReg, wr_reg_e);
        chk("write_data", WriteData, wr_dat_e);
      end
      if (hold && !reset) begin
        chk("hold_valid", rsp_valid, 1);
        chk("hold_reg", rsp_reg, hold_r);
        chk("hold_data", rsp_data, hold_d);
      end
      if (rsp_valid && !reset) begin
        if (exp_q.size() == 0) chk("unexpected_rsp", rsp_valid, 0);
        else begin
          chk("rsp_reg", rsp_reg, exp_q[0].r);
          chk("rsp_data", rsp_data, exp_q[0].d);
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            hs_log.push_back('{cyc, rsp_reg, rsp_data});
          end
        end
      end
      hold   = rsp_valid && !rsp_ready && !reset;
      hold_r = rsp_reg;
      hold_d = rsp_data;
      wr_expect = 0;
      if (reset) exp_q.delete();
      else if (cmd_valid && cmd_ready) begin
        case (cmd_op)
          2'd0: begin
            arch[cmd_reg] = cmd_data;
            wr_expect = 1;
            wr_reg_e  = cmd_reg;
            wr_dat_e  = cmd_data;
          end
          2'd1: exp_q.push_back('{cmd_reg, arch[cmd_reg]});
          2'd2: for (int i = 0; i < 4; i++) exp_q.push_back('{2'(i), arch[i]});
          default: ;
        endcase
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [1:0] r, input logic [7:0] d, output int acc);
    int n;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_reg   = r;
    cmd_data  = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 200);
    acc = cyc;
    if (!cmd_ready) fail("cmd_accept");
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n0);
    int n = 0;
    while (hs_log.size() <= n0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (hs_log.size() <= n0) fail("wait_rsp");
    tick();
  endtask

  task automatic wait_idle(output int c);
    int n = 0;
    c = -1;
    while (n < 60) begin
      @(negedge clk);
      n++;
      if (!busy) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) fail("wait_idle");
    tick();
  endtask

  initial begin
    int acc, acc_w, c_idle, n0, cnt, base;
    int offs [4];
    logic [7:0] dump_vals [4];
    offs      = '{4, 5, 8, 9};
    dump_vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_reg = '0; cmd_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    mon_en = 1;

    // Reset state after three idle cycles
    repeat (3) tick();
    @(negedge clk);
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_reg", rsp_reg, 0);
    chk("rst_rsp_data", rsp_data, 0);
    tick();

    // WRITE reg 2 = A5 then READ reg 2
    send_cmd(2'd0, 2'd2, 8'hA5, acc);
    @(negedge clk);
    chk("wr_pulse", RegWrite, 1);
    chk("wr_reg_lit", WriteReg, 2);
    chk("wr_data_lit", WriteData, 8'hA5);
    @(negedge clk);
    chk("wr_pulse_end", RegWrite, 0);
    chk("wr_ready_back", cmd_ready, 1);
    tick();
    n0 = hs_log.size();
    send_cmd(2'd1, 2'd2, 8'h00, acc);
    wait_rsp(n0);
    chk("rd_latency", hs_log[n0].c - acc, 4);
    chk("rd_reg_lit", hs_log[n0].r, 2);
    chk("rd_data_lit", hs_log[n0].d, 8'hA5);

    // Fill all registers, then DUMP with rsp_ready high
    for (int i = 0; i < 4; i++) send_cmd(2'd0, 2'(i), dump_vals[i], acc);
    n0 = hs_log.size();
    send_cmd(2'd2, 2'd0, 8'h00, acc);
    wait_idle(c_idle);
    chk("dump_busy_len", c_idle - acc, 10);
    chk("dump_count", hs_log.size() - n0, 4);
    if (hs_log.size() - n0 == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("dump_time", hs_log[n0+i].c - acc, offs[i]);
        chk("dump_reg_lit", hs_log[n0+i].r, i);
        chk("dump_data_lit", hs_log[n0+i].d, dump_vals[i]);
      end
    end

    // READ under back-pressure with a WRITE waiting behind it
    ready_mode = 0;
    tick();
    n0 = hs_log.size();
    send_cmd(2'd1, 2'd1, 8'h00, acc);
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_reg = 2'd3; cmd_data = 8'h5A;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("held_cmd_ready", cmd_ready, 0);
      if (rsp_valid) cnt++;
    end
    chk("held_valid_cycles", cnt, 7);
    ready_mode = 1;
    send_cmd(2'd0, 2'd3, 8'h5A, acc_w);
    if (hs_log.size() > n0) begin
      chk("bp_data_lit", hs_log[n0].d, 8'h22);
      chk("wr_after_rsp", acc_w - hs_log[n0].c, 1);
    end else fail("bp_rsp");

    // Reset during RD_WAIT of a DUMP
    send_cmd(2'd2, 2'd0, 8'h00, acc);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_ready", cmd_ready, 1);
    n0 = hs_log.size();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", rsp_valid, 0);
    end
    chk("abort_log", hs_log.size(), n0);
    tick();
    send_cmd(2'd1, 2'd0, 8'h00, acc);
    wait_rsp(n0);
    chk("post_rst_data_lit", hs_log[n0].d, 8'h11);

    // Reserved opcode behaves as a one-cycle NOP
    send_cmd(2'd3, 2'd1, 8'hFF, acc);
    @(negedge clk);
    chk("nop_busy", busy, 0);
    chk("nop_ready", cmd_ready, 1);
    chk("nop_regwrite", RegWrite, 0);
    chk("nop_rsp", rsp_valid, 0);
    tick();

    // Randomized traffic with random response back-pressure
    ready_mode = 2;
    for (int i = 0; i < 250; i++) begin
      send_cmd(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'($urandom), acc);
      repeat ($urandom_range(0, 2)) tick();
    end
    ready_mode = 1;
    base = 0;
    while ((busy || exp_q.size() != 0) && base < 100) begin
      tick();
      base++;
    end
    chk("drain_pending", exp_q.size(), 0);
    chk("drain_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, errors);
    $finish;
  end

endmodule
